// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Shared types and helpers for the snake game datapath.
//   dir_t    : heading encoding (W=00 up, A=01 right, S=10 down, D=11 left)
//   GRID     : playfield edge length in cells
//   coord_t  : one grid coordinate (row or column index)
//   step_t   : result of a single-cell move, with an off-grid flag
//   opposite : heading that would be a 180-degree reversal of the argument
//   step     : applies one move to a coordinate pair, never wrapping
// ---------------------------------------------------------------------------
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_W = 2'b00,
    DIR_A = 2'b01,
    DIR_S = 2'b10,
    DIR_D = 2'b11
  } dir_t;

  localparam int GRID = 16;

  typedef logic [3:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    logic   offGrid;
  } step_t;

  // The encoding is chosen so that flipping the upper bit reverses the heading.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  // A move that would leave the grid reports offGrid and returns the
  // original coordinates unchanged, so callers can simply hold position.
  function automatic step_t step(input coord_t x, input coord_t y, input dir_t d);
    step_t r;
    r.x       = x;
    r.y       = y;
    r.offGrid = 1'b0;
    case (d)
      DIR_W: begin
        if (x == 4'd0) r.offGrid = 1'b1;
        else           r.x = x - 4'd1;
      end
      DIR_A: begin
        if (y == 4'(GRID - 1)) r.offGrid = 1'b1;
        else                   r.y = y + 4'd1;
      end
      DIR_S: begin
        if (x == 4'(GRID - 1)) r.offGrid = 1'b1;
        else                   r.x = x + 4'd1;
      end
      default: begin
        if (y == 4'd0) r.offGrid = 1'b1;
        else           r.y = y - 4'd1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/snake_bitmap_decode.sv
// ---------------------------------------------------------------------------
// snake_bitmap_decode
// Turns an ordered segment list into a GRID x GRID occupancy bitmap.
// Only segments with index FIRST_SEG..len_i-1 are drawn, so stale entries
// past the current length never light a cell. With FIRST_SEG=1 the head is
// left out (body map); with FIRST_SEG=0 the whole snake is drawn (display).
// Ports:
//   segX_i  in  MAX_LEN x 4   segment row indices, index 0 is the head
//   segY_i  in  MAX_LEN x 4   segment column indices
//   len_i   in  7             number of valid segments including the head
//   map_o   out 16x16         occupancy map indexed [X][Y]
// ---------------------------------------------------------------------------
module snake_bitmap_decode
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int FIRST_SEG = 1
) (
  input  coord_t                      segX_i [MAX_LEN],
  input  coord_t                      segY_i [MAX_LEN],
  input  logic   [6:0]                len_i,
  output logic   [GRID-1:0][GRID-1:0] map_o
);

  // Walk every segment slot and set its cell if the slot is inside the
  // current length. Overlapping segments simply set the same bit twice.
  always_comb begin
    map_o = '0;
    for (int i = FIRST_SEG; i < MAX_LEN; i++) begin
      if (7'(i) < len_i) begin
        map_o[segX_i[i]][segY_i[i]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_body_tracker.sv
// ---------------------------------------------------------------------------
// snake_body_tracker
// Owns the snake's position state: head, heading and the ordered segment
// list. Advances one cell per move tick, grows when food is eaten and
// ignores requests to reverse straight back into the body.
// Ports:
//   clk             in   1      system clock
//   reset           in   1      synchronous, active-high
//   enable          in   1      move tick (one-cycle pulse)
//   dirReq          in   2      requested heading (00 W, 01 A, 10 S, 11 D)
//   dirValid        in   1      dirReq is valid this cycle
//   grow            in   1      food eaten (one-cycle pulse)
//   died            in   1      freezes all motion while high
//   snakeHeadX      out  4      head row index
//   snakeHeadY      out  4      head column index
//   snakeDirection  out  2      committed heading
//   GrnPixels       out  16x16  body map [X][Y], head excluded
//   snakeLen        out  7      current length including the head
// ---------------------------------------------------------------------------
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 16,
  parameter int START_X   = 8,
  parameter int START_Y   = 8,
  parameter int START_LEN = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [1:0]                dirReq,
  input  logic                      dirValid,
  input  logic                      grow,
  input  logic                      died,
  output logic [3:0]                snakeHeadX,
  output logic [3:0]                snakeHeadY,
  output logic [1:0]                snakeDirection,
  output logic [GRID-1:0][GRID-1:0] GrnPixels,
  output logic [6:0]                snakeLen
);

  coord_t     segX_q [MAX_LEN];
  coord_t     segY_q [MAX_LEN];
  coord_t     segX_d [MAX_LEN];
  coord_t     segY_d [MAX_LEN];
  logic [6:0] len_q, len_d;
  dir_t       dir_q, dir_d;
  dir_t       pendDir_q, pendDir_d;
  logic       pendValid_q, pendValid_d;
  logic [1:0] pendGrow_q, pendGrow_d;

  logic       dirAccept;
  dir_t       moveDir;
  logic [1:0] growSum;
  step_t      nextStep;

  // Work out everything the next move depends on. The reversal check is made
  // against the committed heading, so a player cannot sneak a reversal in
  // through two quick turns between ticks. A request arriving in the same
  // cycle as the tick is the newest one, so it steers that tick. A grow pulse
  // is folded into the pending count first so a grow arriving with the tick
  // takes effect on that very move.
  always_comb begin
    dirAccept = dirValid && (dir_t'(dirReq) != opposite(dir_q));
    if (dirAccept)        moveDir = dir_t'(dirReq);
    else if (pendValid_q) moveDir = pendDir_q;
    else                  moveDir = dir_q;
    growSum  = (grow && pendGrow_q != 2'd3) ? pendGrow_q + 2'd1 : pendGrow_q;
    nextStep = step(segX_q[0], segY_q[0], moveDir);
  end

  // Next-state logic. Nothing changes while died is high. On a tick the
  // heading always commits (even into a wall, so the collision stage sees
  // the heading that hit it), but the body only shifts and growth is only
  // consumed when the head stays on the grid. Shifting every slot, not just
  // the valid ones, means the old tail is already sitting in slot len when
  // the length increments.
  always_comb begin
    segX_d      = segX_q;
    segY_d      = segY_q;
    len_d       = len_q;
    dir_d       = dir_q;
    pendDir_d   = pendDir_q;
    pendValid_d = pendValid_q;
    pendGrow_d  = pendGrow_q;

    if (!died) begin
      pendGrow_d = growSum;
      if (dirAccept) begin
        pendValid_d = 1'b1;
        pendDir_d   = dir_t'(dirReq);
      end
      if (enable) begin
        dir_d       = moveDir;
        pendValid_d = 1'b0;
        if (!nextStep.offGrid) begin
          for (int i = 1; i < MAX_LEN; i++) begin
            segX_d[i] = segX_q[i-1];
            segY_d[i] = segY_q[i-1];
          end
          segX_d[0] = nextStep.x;
          segY_d[0] = nextStep.y;
          if (growSum != 2'd0) begin
            pendGrow_d = growSum - 2'd1;
            if (len_q < 7'(MAX_LEN)) len_d = len_q + 7'd1;
          end
        end
      end
    end
  end

  // State registers. Reset lays the snake out as a straight line trailing
  // the head in +Y; slots beyond the starting length are filled the same way
  // but stay invisible until the snake grows over them.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        segX_q[i] <= coord_t'(START_X);
        segY_q[i] <= coord_t'(START_Y + i);
      end
      len_q       <= 7'(START_LEN);
      dir_q       <= DIR_D;
      pendDir_q   <= DIR_D;
      pendValid_q <= 1'b0;
      pendGrow_q  <= 2'd0;
    end else begin
      segX_q      <= segX_d;
      segY_q      <= segY_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      pendDir_q   <= pendDir_d;
      pendValid_q <= pendValid_d;
      pendGrow_q  <= pendGrow_d;
    end
  end

  // The body map is decoded straight from the registered segments, so it
  // updates in the same cycle as the head outputs.
  snake_bitmap_decode #(
    .MAX_LEN  (MAX_LEN),
    .FIRST_SEG(1)
  ) u_decode (
    .segX_i(segX_q),
    .segY_i(segY_q),
    .len_i (len_q),
    .map_o (GrnPixels)
  );

  assign snakeHeadX     = segX_q[0];
  assign snakeHeadY     = segY_q[0];
  assign snakeDirection = dir_q;
  assign snakeLen       = len_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// ---------------------------------------------------------------------------
// tb_snake_body_tracker
// Directed bench for snake_body_tracker. A default-sized instance is checked
// throughout; a second instance with MAX_LEN=4 shares the same stimulus and
// is checked where the length cap matters.
// ---------------------------------------------------------------------------
module tb_snake_body_tracker;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 enable = 1'b0;
  logic [1:0]           dirReq = 2'b00;
  logic                 dirValid = 1'b0;
  logic                 grow = 1'b0;
  logic                 died = 1'b0;
  logic [3:0]           headX, headY;
  logic [1:0]           direction;
  logic [15:0][15:0]    grnPixels;
  logic [6:0]           snakeLen;

  logic [3:0]           smallHeadX, smallHeadY;
  logic [1:0]           smallDirection;
  logic [15:0][15:0]    smallPixels;
  logic [6:0]           smallLen;

  int checks = 0;
  int errors = 0;
  logic [15:0][15:0] em;

  always #5 clk = ~clk;

  snake_body_tracker dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .dirReq        (dirReq),
    .dirValid      (dirValid),
    .grow          (grow),
    .died          (died),
    .snakeHeadX    (headX),
    .snakeHeadY    (headY),
    .snakeDirection(direction),
    .GrnPixels     (grnPixels),
    .snakeLen      (snakeLen)
  );

  snake_body_tracker #(.MAX_LEN(4)) dutSmall (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .dirReq        (dirReq),
    .dirValid      (dirValid),
    .grow          (grow),
    .died          (died),
    .snakeHeadX    (smallHeadX),
    .snakeHeadY    (smallHeadY),
    .snakeDirection(smallDirection),
    .GrnPixels     (smallPixels),
    .snakeLen      (smallLen)
  );

  // Drive one cycle of inputs on the falling edge, let the rising edge take
  // them, then release the pulses just after the edge.
  task automatic applyStimulus(input logic en, input logic dv, input logic [1:0] dr,
                               input logic gr);
    @(negedge clk);
    enable   = en;
    dirValid = dv;
    dirReq   = dr;
    grow     = gr;
    @(posedge clk);
    #1;
    enable   = 1'b0;
    dirValid = 1'b0;
    grow     = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state: head (8,8) heading D, body (8,9),(8,10)
    doReset();
    em = '0; em[8][9] = 1'b1; em[8][10] = 1'b1;
    checkOutput("reset headX", headX, 4'd8);
    checkOutput("reset headY", headY, 4'd8);
    checkOutput("reset dir", direction, 2'b11);
    checkOutput("reset len", snakeLen, 7'd3);
    checkOutput("reset map", grnPixels, em);

    // Three plain ticks heading D move Y down by 3
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("tick1 headY", headY, 4'd7);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    em = '0; em[8][6] = 1'b1; em[8][7] = 1'b1;
    checkOutput("tick3 headX", headX, 4'd8);
    checkOutput("tick3 headY", headY, 4'd5);
    checkOutput("tick3 len", snakeLen, 7'd3);
    checkOutput("tick3 map", grnPixels, em);

    // Reversal request (A while heading D) is ignored
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("reversal headX", headX, 4'd8);
    checkOutput("reversal headY", headY, 4'd7);
    checkOutput("reversal dir", direction, 2'b11);

    // W then S between ticks: the last accepted request steers
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 1'b0);
    checkOutput("pending holds dir", direction, 2'b11);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    em = '0; em[8][8] = 1'b1; em[8][9] = 1'b1;
    checkOutput("lastwins headX", headX, 4'd9);
    checkOutput("lastwins headY", headY, 4'd8);
    checkOutput("lastwins dir", direction, 2'b10);
    checkOutput("lastwins map", grnPixels, em);

    // Grow with the tick grows on that tick; old tail (8,10) retained
    doReset();
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
    em = '0; em[8][8] = 1'b1; em[8][9] = 1'b1; em[8][10] = 1'b1;
    checkOutput("grow len", snakeLen, 7'd4);
    checkOutput("grow map", grnPixels, em);
    checkOutput("small grow len", smallLen, 7'd4);
    // Four grows saturate the pending count at 3; four ticks then add 3
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
    checkOutput("grow no tick len", snakeLen, 7'd4);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    em = '0;
    for (int y = 4; y <= 9; y++) em[8][y] = 1'b1;
    checkOutput("sat headY", headY, 4'd3);
    checkOutput("sat len", snakeLen, 7'd7);
    checkOutput("sat map", grnPixels, em);
    em = '0; em[8][4] = 1'b1; em[8][5] = 1'b1; em[8][6] = 1'b1;
    checkOutput("small cap len", smallLen, 7'd4);
    checkOutput("small cap map", smallPixels, em);

    // Walk W to the top edge, then push into the wall with a grow
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    em = '0; em[1][8] = 1'b1; em[2][8] = 1'b1;
    checkOutput("edge headX", headX, 4'd0);
    checkOutput("edge dir", direction, 2'b00);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
    checkOutput("wall headX", headX, 4'd0);
    checkOutput("wall headY", headY, 4'd8);
    checkOutput("wall len", snakeLen, 7'd3);
    checkOutput("wall map", grnPixels, em);
    // Turn A: the grow held back at the wall is consumed now
    applyStimulus(1'b0, 1'b1, 2'b01, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    em = '0; em[0][8] = 1'b1; em[1][8] = 1'b1; em[2][8] = 1'b1;
    checkOutput("after wall headY", headY, 4'd9);
    checkOutput("after wall len", snakeLen, 7'd4);
    checkOutput("after wall map", grnPixels, em);
    // Turn W into the wall: heading commits, position holds
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkOutput("wallhit dir", direction, 2'b00);
    checkOutput("wallhit headX", headX, 4'd0);
    checkOutput("wallhit headY", headY, 4'd9);
    checkOutput("wallhit map", grnPixels, em);

    // died freezes everything, including turns and growth
    @(negedge clk);
    died = 1'b1;
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
    checkOutput("died headX", headX, 4'd0);
    checkOutput("died headY", headY, 4'd9);
    checkOutput("died dir", direction, 2'b00);
    checkOutput("died len", snakeLen, 7'd4);
    checkOutput("died map", grnPixels, em);

    // Reset with two grows pending clears them
    @(negedge clk);
    died = 1'b0;
    doReset();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
    doReset();
    checkOutput("rst grow len", snakeLen, 7'd3);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    em = '0; em[8][8] = 1'b1; em[8][9] = 1'b1;
    checkOutput("rst grow tick len", snakeLen, 7'd3);
    checkOutput("rst grow tick headY", headY, 4'd7);
    checkOutput("rst grow tick map", grnPixels, em);

    // Reset dominates a simultaneous tick and grow
    @(negedge clk);
    reset  = 1'b1;
    enable = 1'b1;
    grow   = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    grow   = 1'b0;
    checkOutput("rst dom headY", headY, 4'd8);
    checkOutput("rst dom len", snakeLen, 7'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
